// File: rtl/button_pkg.sv
// Shared types and defaults for the button debouncer.
package button_pkg;

  localparam int unsigned STABLE_COUNT_DEFAULT = 4;

  typedef enum logic [1:0] {
    StReleased,
    StPressCheck,
    StPressed,
    StReleaseCheck
  } state_t;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input into the clock_in domain.
module sync_2ff (
  input  logic clock_in,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;

  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  always_ff @(posedge clock_in) begin
    if (reset) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/button_debouncer.sv
// Debounces a mechanical button by requiring STABLE_COUNT identical samples on sample_clk ticks,
// producing a registered level plus one-cycle press/release strobes.
module button_debouncer
  import button_pkg::*;
#(
  parameter int unsigned STABLE_COUNT = STABLE_COUNT_DEFAULT
) (
  input  logic clock_in,
  input  logic reset,
  input  logic sample_clk,
  input  logic button_in,
  output logic button_level,
  output logic press_pulse,
  output logic release_pulse
);

  localparam int unsigned CntW = $clog2(STABLE_COUNT + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(STABLE_COUNT);
  localparam logic [CntW-1:0] CntOne = CntW'(1);

  logic btn_sync;
  logic sample_d_q, sample_d_d;
  logic sample_tick;

  state_t state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d, cnt_inc;
  logic level_q, level_d;
  logic press_q, press_d;
  logic release_q, release_d;

  sync_2ff u_sync (
    .clock_in (clock_in),
    .reset    (reset),
    .d        (button_in),
    .q        (btn_sync)
  );

  // sample_d_q resets high so a sample_clk already high at reset release does not tick.
  always_comb begin
    sample_d_d  = sample_clk;
    sample_tick = sample_clk & ~sample_d_q;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cnt_inc = cnt_q + CntOne;
    if (sample_tick) begin
      unique case (state_q)
        StReleased: begin
          if (btn_sync) begin
            state_d = StPressCheck;
            cnt_d   = CntOne;
          end else begin
            cnt_d = '0;
          end
        end
        StPressCheck: begin
          if (btn_sync) begin
            if (cnt_inc == CntMax) begin
              state_d = StPressed;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_inc;
            end
          end else begin
            state_d = StReleased;
            cnt_d   = '0;
          end
        end
        StPressed: begin
          if (!btn_sync) begin
            state_d = StReleaseCheck;
            cnt_d   = CntOne;
          end else begin
            cnt_d = '0;
          end
        end
        StReleaseCheck: begin
          if (!btn_sync) begin
            if (cnt_inc == CntMax) begin
              state_d = StReleased;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_inc;
            end
          end else begin
            state_d = StPressed;
            cnt_d   = '0;
          end
        end
        default: begin
          state_d = StReleased;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Outputs are registered from the next state so they line up with state_q.
  always_comb begin
    level_d   = (state_d == StPressed) || (state_d == StReleaseCheck);
    press_d   = level_d & ~level_q;
    release_d = ~level_d & level_q;
  end

  always_ff @(posedge clock_in) begin
    if (reset) begin
      sample_d_q <= 1'b1;
      state_q    <= StReleased;
      cnt_q      <= '0;
      level_q    <= 1'b0;
      press_q    <= 1'b0;
      release_q  <= 1'b0;
    end else begin
      sample_d_q <= sample_d_d;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      level_q    <= level_d;
      press_q    <= press_d;
      release_q  <= release_d;
    end
  end

  assign button_level  = level_q;
  assign press_pulse   = press_q;
  assign release_pulse = release_q;

endmodule

// File: tb/tb_button_debouncer.sv
// Scoreboard bench: stimulus queues expected strobes, a monitor pops them as the DUT pulses.
module tb_button_debouncer;

  logic clk;
  logic reset;
  logic sample_clk;
  logic button_in;
  logic button_level;
  logic press_pulse;
  logic release_pulse;
  logic gen_en;

  typedef struct {
    bit  is_press;
    time t;
  } ev_t;

  ev_t sb[$];
  int  checks;
  int  errors;
  bit  exp_level;

  button_debouncer #(
    .STABLE_COUNT (4)
  ) dut (
    .clock_in      (clk),
    .reset         (reset),
    .sample_clk    (sample_clk),
    .button_in     (button_in),
    .button_level  (button_level),
    .press_pulse   (press_pulse),
    .release_pulse (release_pulse)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // 100 Hz stand-in: toggles every 10 clock cycles once enabled.
  initial begin
    sample_clk = 1'b1;
    wait (gen_en);
    forever begin
      repeat (10) @(negedge clk);
      sample_clk = ~sample_clk;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, time %0t", $time);
    $fatal(1);
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: pops one expectation per strobe and tracks the expected level.
  initial begin
    exp_level = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (reset) begin
        exp_level = 1'b0;
        check("reset_level", int'(button_level), 0);
        check("reset_pulses", int'({press_pulse, release_pulse}), 0);
      end else begin
        if (press_pulse && release_pulse) begin
          check("both_pulses", 1, 0);
        end else if (press_pulse || release_pulse) begin
          if (sb.size() == 0) begin
            check("unexpected_pulse_is_press", int'(press_pulse), -1);
          end else begin
            ev_t e;
            e = sb.pop_front();
            check("pulse_kind_is_press", int'(press_pulse), int'(e.is_press));
            check("pulse_time", int'(($time - e.t) == 0), 1);
            exp_level = e.is_press;
          end
        end
        check("level", int'(button_level), int'(exp_level));
      end
    end
  end

  task automatic wait_tick();
    @(posedge sample_clk);
    @(posedge clk);
  endtask

  task automatic mid();
    @(negedge sample_clk);
  endtask

  // Called on the tick edge that should accept the new level.
  task automatic expect_event(input bit is_press);
    ev_t e;
    e.is_press = is_press;
    e.t        = $time + 1;
    sb.push_back(e);
    #2;
    check(is_press ? "press_seen" : "release_seen", sb.size(), 0);
  endtask

  task automatic do_reset(input int cycles);
    reset = 1'b1;
    repeat (cycles) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic press_4();
    mid();
    button_in = 1'b1;
    repeat (4) wait_tick();
    expect_event(1'b1);
  endtask

  task automatic release_4();
    mid();
    button_in = 1'b0;
    repeat (4) wait_tick();
    expect_event(1'b0);
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    gen_en    = 1'b0;
    button_in = 1'b1;
    reset     = 1'b1;

    // Reset with button and sample_clk high; acceptance needs 4 real ticks.
    @(negedge clk);
    do_reset(5);
    gen_en = 1'b1;
    repeat (4) wait_tick();
    expect_event(1'b1);

    release_4();

    // Bounce: high for 2 ticks, low at the 3rd.
    mid();
    button_in = 1'b1;
    repeat (2) wait_tick();
    mid();
    button_in = 1'b0;
    wait_tick();
    #2;
    check("bounce_level", int'(button_level), 0);
    press_4();
    release_4();

    // Reset after 3 ticks of press checking discards the partial count.
    mid();
    button_in = 1'b1;
    repeat (3) wait_tick();
    mid();
    do_reset(5);
    #1;
    check("midcheck_reset_level", int'(button_level), 0);
    repeat (4) wait_tick();
    expect_event(1'b1);

    // Reset while pressed: level drops with no release strobe.
    mid();
    do_reset(5);
    #1;
    check("pressed_reset_level", int'(button_level), 0);
    repeat (4) wait_tick();
    expect_event(1'b1);
    release_4();

    // Glitches fully between ticks are never sampled.
    wait_tick();
    repeat (3) @(negedge clk);
    button_in = 1'b1;
    repeat (5) @(negedge clk);
    button_in = 1'b0;
    repeat (2) wait_tick();
    #2;
    check("glitch_released_level", int'(button_level), 0);

    press_4();
    wait_tick();
    repeat (3) @(negedge clk);
    button_in = 1'b0;
    repeat (5) @(negedge clk);
    button_in = 1'b1;
    repeat (2) wait_tick();
    #2;
    check("glitch_pressed_level", int'(button_level), 1);
    release_4();

    repeat (30) @(negedge clk);
    check("scoreboard_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
